// File: rtl/fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_arbiter
// Purpose  : Round-robin arbiter and sequencer that lets two requesters share
//            one pipelined single-precision multiplier. Operand pairs are
//            accepted through valid/ready handshakes, registered onto the
//            multiplier inputs, and their owner is carried down a tag pipeline
//            that matches the multiplier latency. Results are routed back to
//            the owning requester, and each requester keeps sticky exception
//            flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LAT          multiplier latency in cycles (legal range 1..8)
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   reqN_valid   requester N presents an operand pair
//   reqN_ready   grant to requester N (combinational)
//   reqN_a/b     requester N operands (IEEE-754 single)
//   mul_a/b      registered operands driven to the multiplier
//   mul_z        multiplier result
//   mul_status   multiplier status {0,0,inexact,huge,tiny,nan,inf,zero}
//   rspN_valid   one-cycle result pulse to requester N
//   rspN_z       registered result for requester N
//   rspN_status  registered status for requester N
//   stickyN      accumulated status bits [5:0] for requester N
//   clr_stickyN  synchronous clear of stickyN
//   busy         at least one operation is in flight
// ============================================================================
module fp_mul_arbiter #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_z,
    input  logic [7:0]  mul_status,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_z,
    output logic [7:0]  rsp0_status,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_z,
    output logic [7:0]  rsp1_status,
    output logic [7:0]  sticky0,
    output logic [7:0]  sticky1,
    input  logic        clr_sticky0,
    input  logic        clr_sticky1,
    output logic        busy
);

    // Requester id of the most recent completed handshake (1 = requester 1).
    logic        r_last_grant;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;

    // Tag pipeline: index 0 is loaded on the handshake edge, index LAT lines
    // up with the cycle in which mul_z/mul_status belong to that operation.
    logic [LAT:0] r_stg_vld;
    logic [LAT:0] r_stg_tag;

    logic        r_rsp0_valid;
    logic [31:0] r_rsp0_z;
    logic [7:0]  r_rsp0_status;
    logic        r_rsp1_valid;
    logic [31:0] r_rsp1_z;
    logic [7:0]  r_rsp1_status;
    logic [7:0]  r_sticky0;
    logic [7:0]  r_sticky1;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_cap0;
    logic        w_cap1;
    logic [7:0]  w_new_flags;

    // ------------------------------------------------------------------------
    // Arbitration: a lone requester always wins; on a tie the requester that
    // was not granted last wins. The two terms are mutually exclusive.
    // ------------------------------------------------------------------------
    always_comb begin
        w_grant0 = req0_valid & (~req1_valid |  r_last_grant);
        w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // ------------------------------------------------------------------------
    // Issue register: operands only change on a handshake, so the multiplier
    // inputs stay quiet while idle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_mul_a      <= 32'h0;
            r_mul_b      <= 32'h0;
        end else if (w_grant0) begin
            r_last_grant <= 1'b0;
            r_mul_a      <= req0_a;
            r_mul_b      <= req0_b;
        end else if (w_grant1) begin
            r_last_grant <= 1'b1;
            r_mul_a      <= req1_a;
            r_mul_b      <= req1_b;
        end
    end

    assign mul_a = r_mul_a;
    assign mul_b = r_mul_b;

    // ------------------------------------------------------------------------
    // Tag pipeline, shifted every cycle regardless of traffic.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_vld <= '0;
            r_stg_tag <= '0;
        end else begin
            r_stg_vld[0]     <= w_grant0 | w_grant1;
            r_stg_tag[0]     <= w_grant1;
            r_stg_vld[LAT:1] <= r_stg_vld[LAT-1:0];
            r_stg_tag[LAT:1] <= r_stg_tag[LAT-1:0];
        end
    end

    assign busy = |r_stg_vld;

    // ------------------------------------------------------------------------
    // Response capture and sticky flags.
    // ------------------------------------------------------------------------
    always_comb begin
        w_cap0      = r_stg_vld[LAT] & ~r_stg_tag[LAT];
        w_cap1      = r_stg_vld[LAT] &  r_stg_tag[LAT];
        w_new_flags = {2'b00, mul_status[5:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp0_valid  <= 1'b0;
            r_rsp0_z      <= 32'h0;
            r_rsp0_status <= 8'h0;
            r_rsp1_valid  <= 1'b0;
            r_rsp1_z      <= 32'h0;
            r_rsp1_status <= 8'h0;
        end else begin
            r_rsp0_valid <= w_cap0;
            r_rsp1_valid <= w_cap1;
            if (w_cap0) begin
                r_rsp0_z      <= mul_z;
                r_rsp0_status <= mul_status;
            end
            if (w_cap1) begin
                r_rsp1_z      <= mul_z;
                r_rsp1_status <= mul_status;
            end
        end
    end

    // A clear coinciding with a capture keeps only the freshly captured bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky0 <= 8'h0;
            r_sticky1 <= 8'h0;
        end else begin
            if (w_cap0) begin
                r_sticky0 <= (clr_sticky0 ? 8'h00 : r_sticky0) | w_new_flags;
            end else if (clr_sticky0) begin
                r_sticky0 <= 8'h00;
            end
            if (w_cap1) begin
                r_sticky1 <= (clr_sticky1 ? 8'h00 : r_sticky1) | w_new_flags;
            end else if (clr_sticky1) begin
                r_sticky1 <= 8'h00;
            end
        end
    end

    assign rsp0_valid  = r_rsp0_valid;
    assign rsp0_z      = r_rsp0_z;
    assign rsp0_status = r_rsp0_status;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp1_z      = r_rsp1_z;
    assign rsp1_status = r_rsp1_status;
    assign sticky0     = r_sticky0;
    assign sticky1     = r_sticky1;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_arbiter
// Purpose  : Self-checking bench for fp_mul_arbiter. Two instances (LAT=2 and
//            LAT=4) share one stimulus stream, each with its own multiplier
//            model and reference scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_arbiter;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        c0;
        logic        c1;
        logic        e0;
        logic        e1;
    } vec_t;

    typedef struct {
        logic        req;
        logic [31:0] z;
        logic [7:0]  st;
        int          cap;
    } item_t;

    localparam int NV = 43;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic        req1_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        clr_sticky0;
    logic        clr_sticky1;

    logic [1:0]  req0_ready_w;
    logic [1:0]  req1_ready_w;
    logic [1:0]  rsp0_valid_w;
    logic [1:0]  rsp1_valid_w;
    logic [1:0]  busy_w;
    logic [31:0] mul_a_w   [2];
    logic [31:0] mul_b_w   [2];
    logic [31:0] rsp0_z_w  [2];
    logic [31:0] rsp1_z_w  [2];
    logic [7:0]  rsp0_st_w [2];
    logic [7:0]  rsp1_st_w [2];
    logic [7:0]  sticky0_w [2];
    logic [7:0]  sticky1_w [2];

    int n_tests = 0;
    int n_fail  = 0;

    vec_t tbl [NV];

    // Stand-in multiplier: 2.0 * 3.0 gives the true product; anything else
    // gives a scrambled but deterministic value. Status is b[7:0].
    function automatic logic [31:0] fz(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    function automatic vec_t mk(input logic v0, input logic v1,
                                input logic [31:0] a0, input logic [31:0] b0,
                                input logic [31:0] a1, input logic [31:0] b1,
                                input logic c0, input logic c1,
                                input logic e0, input logic e1);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
        v.c0 = c0; v.c1 = c1; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic chk(input int inst, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL lat_inst%0d %s: got %h expected %h (t=%0t)",
                     inst, name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int LATI = (gi == 0) ? 2 : 4;

        logic [31:0] mul_z;
        logic [7:0]  mul_status;
        logic [31:0] zp [LATI];
        logic [7:0]  sp [LATI];
        item_t       sb [$];

        fp_mul_arbiter #(.LAT(LATI)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .req0_valid  (req0_valid),
            .req0_ready  (req0_ready_w[gi]),
            .req0_a      (req0_a),
            .req0_b      (req0_b),
            .req1_valid  (req1_valid),
            .req1_ready  (req1_ready_w[gi]),
            .req1_a      (req1_a),
            .req1_b      (req1_b),
            .mul_a       (mul_a_w[gi]),
            .mul_b       (mul_b_w[gi]),
            .mul_z       (mul_z),
            .mul_status  (mul_status),
            .rsp0_valid  (rsp0_valid_w[gi]),
            .rsp0_z      (rsp0_z_w[gi]),
            .rsp0_status (rsp0_st_w[gi]),
            .rsp1_valid  (rsp1_valid_w[gi]),
            .rsp1_z      (rsp1_z_w[gi]),
            .rsp1_status (rsp1_st_w[gi]),
            .sticky0     (sticky0_w[gi]),
            .sticky1     (sticky1_w[gi]),
            .clr_sticky0 (clr_sticky0),
            .clr_sticky1 (clr_sticky1),
            .busy        (busy_w[gi])
        );

        // Multiplier model: LATI-deep pipeline from the registered operands.
        always @(posedge clk) begin
            zp[0] <= fz(mul_a_w[gi], mul_b_w[gi]);
            sp[0] <= mul_b_w[gi][7:0];
            for (int k = 1; k < LATI; k++) begin
                zp[k] <= zp[k-1];
                sp[k] <= sp[k-1];
            end
        end
        assign mul_z      = zp[LATI-1];
        assign mul_status = sp[LATI-1];

        // Reference model and scoreboard. Each tick runs 2 ns before a rising
        // edge: it first checks the state left by the previous edge, then
        // predicts what the coming edge does.
        initial begin : p_model
            int          ecount;
            logic        m_last, m_v0, m_v1, m_busy, g0, g1, cap;
            logic [31:0] m_z0, m_z1, m_ma, m_mb;
            logic [7:0]  m_st0, m_st1, m_s0, m_s1;
            item_t       it;
            item_t       nw;
            ecount = 0;
            m_last = 1'b1; m_v0 = 1'b0; m_v1 = 1'b0; m_busy = 1'b0;
            m_z0 = '0; m_z1 = '0; m_ma = '0; m_mb = '0;
            m_st0 = '0; m_st1 = '0; m_s0 = '0; m_s1 = '0;
            forever begin
                @(negedge clk);
                #3;
                ecount++;
                if (!rst_n) begin
                    sb.delete();
                    m_last = 1'b1; m_v0 = 1'b0; m_v1 = 1'b0; m_busy = 1'b0;
                    m_z0 = '0; m_z1 = '0; m_ma = '0; m_mb = '0;
                    m_st0 = '0; m_st1 = '0; m_s0 = '0; m_s1 = '0;
                end else begin
                    chk(gi, "rsp0_valid",  32'(rsp0_valid_w[gi]), 32'(m_v0));
                    chk(gi, "rsp1_valid",  32'(rsp1_valid_w[gi]), 32'(m_v1));
                    chk(gi, "rsp0_z",      rsp0_z_w[gi], m_z0);
                    chk(gi, "rsp1_z",      rsp1_z_w[gi], m_z1);
                    chk(gi, "rsp0_status", 32'(rsp0_st_w[gi]), 32'(m_st0));
                    chk(gi, "rsp1_status", 32'(rsp1_st_w[gi]), 32'(m_st1));
                    chk(gi, "sticky0",     32'(sticky0_w[gi]), 32'(m_s0));
                    chk(gi, "sticky1",     32'(sticky1_w[gi]), 32'(m_s1));
                    chk(gi, "busy",        32'(busy_w[gi]), 32'(m_busy));
                    chk(gi, "mul_a",       mul_a_w[gi], m_ma);
                    chk(gi, "mul_b",       mul_b_w[gi], m_mb);

                    g0 = req0_valid && (!req1_valid || m_last);
                    g1 = req1_valid && !g0;
                    chk(gi, "req0_ready", 32'(req0_ready_w[gi]), 32'(g0));
                    chk(gi, "req1_ready", 32'(req1_ready_w[gi]), 32'(g1));

                    m_v0 = 1'b0;
                    m_v1 = 1'b0;
                    cap  = 1'b0;
                    if (sb.size() != 0 && sb[0].cap == ecount) begin
                        it  = sb.pop_front();
                        cap = 1'b1;
                        if (it.req) begin
                            m_v1 = 1'b1; m_z1 = it.z; m_st1 = it.st;
                        end else begin
                            m_v0 = 1'b1; m_z0 = it.z; m_st0 = it.st;
                        end
                    end
                    if (cap && !it.req)   m_s0 = (clr_sticky0 ? 8'h00 : m_s0) | {2'b00, it.st[5:0]};
                    else if (clr_sticky0) m_s0 = 8'h00;
                    if (cap && it.req)    m_s1 = (clr_sticky1 ? 8'h00 : m_s1) | {2'b00, it.st[5:0]};
                    else if (clr_sticky1) m_s1 = 8'h00;

                    if (g0 || g1) begin
                        m_ma   = g1 ? req1_a : req0_a;
                        m_mb   = g1 ? req1_b : req0_b;
                        m_last = g1;
                        nw.req = g1;
                        nw.z   = fz(m_ma, m_mb);
                        nw.st  = m_mb[7:0];
                        nw.cap = ecount + LATI + 1;
                        sb.push_back(nw);
                    end
                    m_busy = (sb.size() != 0);
                end
            end
        end
    end

    initial begin : p_stim
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        clr_sticky0 = 1'b0; clr_sticky1 = 1'b0;

        // Contention right after reset: grants 0,1,0,1,0,1. Row 2 carries
        // status bit 7, which must not reach sticky0.
        for (int i = 0; i < 6; i++)
            tbl[i] = mk(1'b1, 1'b1, 32'h3F800000 + i, 32'h40000000 | ((i == 2) ? 32'h80 : 32'h0),
                        32'h3FA00000 + i, 32'h40100000, 1'b0, 1'b0, (i % 2 == 0), (i % 2 == 1));
        for (int i = 6; i < NV; i++)
            tbl[i] = mk(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Single request: 2.0 * 3.0
        tbl[12] = mk(1'b1, 1'b0, 32'h40000000, 32'h40400000, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Sticky accumulation on requester 1: 0x01, 0x02, 0x20
        tbl[18] = mk(1'b0, 1'b1, '0, '0, 32'h3F800000, 32'h3FC00001, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[19] = mk(1'b0, 1'b1, '0, '0, 32'h3F900000, 32'h3FC00002, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[20] = mk(1'b0, 1'b1, '0, '0, 32'h3FA00000, 32'h3FC00020, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[27] = mk(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Clear collision: sticky0 = 0x04, then clear on the capture edge of 0x10
        tbl[28] = mk(1'b1, 1'b0, 32'h3F800000, 32'h3FC00004, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[35] = mk(1'b1, 1'b0, 32'h3F880000, 32'h3FC00010, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[38] = mk(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
            req0_a = tbl[i].a0; req0_b = tbl[i].b0;
            req1_a = tbl[i].a1; req1_b = tbl[i].b1;
            clr_sticky0 = tbl[i].c0; clr_sticky1 = tbl[i].c1;
            #2;
            for (int k = 0; k < 2; k++) begin
                chk(k, "tbl_ready0", 32'(req0_ready_w[k]), 32'(tbl[i].e0));
                chk(k, "tbl_ready1", 32'(req1_ready_w[k]), 32'(tbl[i].e1));
                if (i == 19) chk(k, "single_rsp0_z", rsp0_z_w[k], 32'h40C00000);
                if (i == 27) chk(k, "sticky1_accum", 32'(sticky1_w[k]), 32'h23);
                if (i == 28) chk(k, "sticky1_cleared", 32'(sticky1_w[k]), 32'h00);
            end
        end
        for (int k = 0; k < 2; k++)
            chk(k, "sticky0_collision", 32'(sticky0_w[k]), 32'h10);

        // Reset with two operations in flight.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000001;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h3F800000; req1_b = 32'h40000002;
        @(negedge clk);
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) chk(k, "busy_before_rst", 32'(busy_w[k]), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(k, "rst_mul_a",   mul_a_w[k], 32'h0);
            chk(k, "rst_mul_b",   mul_b_w[k], 32'h0);
            chk(k, "rst_rsp0_z",  rsp0_z_w[k], 32'h0);
            chk(k, "rst_rsp1_z",  rsp1_z_w[k], 32'h0);
            chk(k, "rst_rsp_st",  {16'h0, rsp1_st_w[k], rsp0_st_w[k]}, 32'h0);
            chk(k, "rst_sticky",  {16'h0, sticky1_w[k], sticky0_w[k]}, 32'h0);
            chk(k, "rst_valids",  32'({busy_w[k], rsp1_valid_w[k], rsp0_valid_w[k]}), 32'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // First tie after reset goes to requester 0.
        req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40400000;
        req1_valid = 1'b1; req1_a = 32'h3F800000; req1_b = 32'h3F800000;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk(k, "tie_after_rst_ready0", 32'(req0_ready_w[k]), 32'h1);
            chk(k, "tie_after_rst_ready1", 32'(req1_ready_w[k]), 32'h0);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
